// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, column drive
// patterns, the column/row to hex key map, and a row priority helper.
package kypd_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } kypdState_e;

  // Rows are pulled up, so an untouched keypad reads all ones.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // No column driven; each scan column pulls exactly one bit low.
  localparam logic [3:0] COL_IDLE = 4'b1111;

  localparam logic [3:0] COL_DRIVE [4] = '{
    COL_IDLE & ~4'b0001,
    COL_IDLE & ~4'b0010,
    COL_IDLE & ~4'b0100,
    COL_IDLE & ~4'b1000
  };

  // Indexed by {column, row}.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,
    4'h2, 4'h5, 4'h8, 4'hF,
    4'h3, 4'h6, 4'h9, 4'hE,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  // Index of the lowest-numbered row that is pulled low (0 if none).
  function automatic logic [1:0] lowestLowRow(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs such as keypad rows,
// switches and buttons.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give metastability time to resolve.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 Pmod keypad one column at a time, debounces the rows and
// presents a hex key code with a held flag and an acknowledgeable pending flag.
module keypad_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output logic [3:0] keyCode_o,
  output logic       keyHeld_o,
  output logic       keyPend_o,
  input  logic       keyAck_i
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       rowsSync;
  logic [DIV_W-1:0] divCnt_q;
  logic             scanTick;

  kypdState_e       state_q, state_d;
  logic [1:0]       colIdx_q, colIdx_d;
  logic [CNT_W-1:0] debCnt_q, debCnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       keyCode_q, keyCode_d;
  logic             keyHeld_q, keyHeld_d;
  logic             keyPend_q, keyPend_d;

  logic             allHigh;
  logic [3:0]       sampleCode;
  logic [CNT_W-1:0] debCntInc;
  logic             accept;

  sync_2ff #(
    .WIDTH    (4),
    .RESET_VAL(ROWS_IDLE)
  ) u_rowSync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rows_i),
    .q_o   (rowsSync)
  );

  // Free-running dwell divider; the tick marks the end of each column dwell.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divCnt_q <= '0;
    end else if (divCnt_q == DIV_LAST) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

  assign scanTick   = (divCnt_q == DIV_LAST);
  assign allHigh    = (rowsSync == ROWS_IDLE);
  assign sampleCode = KEY_MAP[{colIdx_q, lowestLowRow(rowsSync)}];
  assign debCntInc  = debCnt_q + 1'b1;

  // State and output registers for the scan/debounce FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SCAN;
      colIdx_q  <= 2'd0;
      debCnt_q  <= '0;
      cand_q    <= 4'h0;
      keyCode_q <= 4'h0;
      keyHeld_q <= 1'b0;
      keyPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      colIdx_q  <= colIdx_d;
      debCnt_q  <= debCnt_d;
      cand_q    <= cand_d;
      keyCode_q <= keyCode_d;
      keyHeld_q <= keyHeld_d;
      keyPend_q <= keyPend_d;
    end
  end

  // Next-state logic; rows are only looked at on the dwell tick.
  always_comb begin
    state_d   = state_q;
    colIdx_d  = colIdx_q;
    debCnt_d  = debCnt_q;
    cand_d    = cand_q;
    keyCode_d = keyCode_q;
    keyHeld_d = keyHeld_q;
    accept    = 1'b0;

    if (scanTick) begin
      case (state_q)
        SCAN: begin
          if (allHigh) begin
            colIdx_d = colIdx_q + 2'd1;
          end else begin
            cand_d = sampleCode;
            if (CNT_ONE == CNT_DONE) begin
              accept = 1'b1;
            end else begin
              debCnt_d = CNT_ONE;
              state_d  = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!allHigh && (sampleCode == cand_q)) begin
            if (debCntInc == CNT_DONE) begin
              accept = 1'b1;
            end else begin
              debCnt_d = debCntInc;
            end
          end else begin
            debCnt_d = '0;
            state_d  = SCAN;
          end
        end
        PRESSED: begin
          if (allHigh) begin
            if (debCntInc == CNT_DONE) begin
              keyHeld_d = 1'b0;
              debCnt_d  = '0;
              state_d   = SCAN;
            end else begin
              debCnt_d = debCntInc;
            end
          end else begin
            debCnt_d = '0;
          end
        end
        default: begin
          debCnt_d = '0;
          state_d  = SCAN;
        end
      endcase
    end

    if (accept) begin
      keyCode_d = cand_d;
      keyHeld_d = 1'b1;
      debCnt_d  = '0;
      state_d   = PRESSED;
    end

    keyPend_d = accept | (keyPend_q & ~keyAck_i);
  end

  assign cols_o    = COL_DRIVE[colIdx_q];
  assign keyCode_o = keyCode_q;
  assign keyHeld_o = keyHeld_q;
  assign keyPend_o = keyPend_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives the
// rows from the column outputs, and a behavioural model predicts every output
// on every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV  = 8;
  localparam int DEB       = 3;
  localparam int M_SCAN    = 0;
  localparam int M_DEB     = 1;
  localparam int M_PRESSED = 2;

  typedef struct {
    int         mode;
    int         col;
    int         cnt;
    int         cand;
    int         code;
    bit         held;
    bit         pend;
    int         div;
    logic [3:0] hOld;
    logic [3:0] hNew;
    bit         accepted;
  } mdl_t;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  rows_i;
  logic [3:0]  cols_o;
  logic [3:0]  keyCode_o;
  logic        keyHeld_o;
  logic        keyPend_o;
  logic        keyAck_i;
  logic [15:0] keyDown;

  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;
  int   pendRises  = 0;
  bit   prevPend   = 1'b0;
  mdl_t m;

  int keyMap [4][4] = '{
    '{1, 4, 7, 0},
    '{2, 5, 8, 15},
    '{3, 6, 9, 14},
    '{10, 11, 12, 13}
  };

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rows_i   (rows_i),
    .cols_o   (cols_o),
    .keyCode_o(keyCode_o),
    .keyHeld_o(keyHeld_o),
    .keyPend_o(keyPend_o),
    .keyAck_i (keyAck_i)
  );

  // 100 MHz style clock, rising edges at 5, 15, 25 ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // A pressed key shorts its row to its column, so the row reads low only
  // while that column is being driven low.
  always_comb begin
    rows_i = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keyDown[c*4+r] && !cols_o[c]) rows_i[r] = 1'b0;
      end
    end
  end

  function automatic mdl_t resetModel();
    mdl_t s;
    s.mode = M_SCAN; s.col = 0; s.cnt = 0; s.cand = 0; s.code = 0;
    s.held = 1'b0; s.pend = 1'b0; s.div = 0;
    s.hOld = 4'hF; s.hNew = 4'hF; s.accepted = 1'b0;
    return s;
  endfunction

  function automatic logic [3:0] colsOf(input int c);
    return 4'hF & ~(4'b0001 << c);
  endfunction

  // Behavioural reference: rows reach the decision logic two edges after
  // they are presented, and the decision only happens at the end of a dwell.
  function automatic mdl_t modelNext(input mdl_t s, input logic [3:0] rowsNow, input bit ack);
    mdl_t       n;
    logic [3:0] seen;
    int         row;
    int         keyVal;
    n = s;
    n.accepted = 1'b0;
    seen   = s.hOld;
    n.hOld = s.hNew;
    n.hNew = rowsNow;
    if (s.div == SCAN_DIV - 1) begin
      row = -1;
      for (int r = 3; r >= 0; r--) if (seen[r] == 1'b0) row = r;
      keyVal = -1;
      if (row >= 0) keyVal = keyMap[s.col][row];
      case (s.mode)
        M_SCAN: begin
          if (row < 0) n.col = (s.col + 1) % 4;
          else begin n.cand = keyVal; n.cnt = 1; n.mode = M_DEB; end
        end
        M_DEB: begin
          if (keyVal == s.cand) n.cnt = s.cnt + 1;
          else begin n.cnt = 0; n.mode = M_SCAN; end
        end
        default: begin
          n.cnt = (row < 0) ? s.cnt + 1 : 0;
          if (n.cnt == DEB) begin n.held = 1'b0; n.cnt = 0; n.mode = M_SCAN; end
        end
      endcase
      if (n.mode == M_DEB && n.cnt == DEB) begin
        n.code = n.cand; n.held = 1'b1; n.cnt = 0; n.mode = M_PRESSED; n.accepted = 1'b1;
      end
    end
    n.div  = (s.div + 1) % SCAN_DIV;
    n.pend = n.accepted ? 1'b1 : (ack ? 1'b0 : s.pend);
    return n;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      if (failCount <= 30)
        $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Press or release one key on the keypad model.
  task automatic applyStimulus(input int col, input int row, input bit down);
    keyDown[col*4+row] = down;
  endtask

  // Advance one clock; optionally pulse ack on this edge, or only if the
  // model says this edge accepts a key. Checks every output afterwards.
  task automatic stepCycle(input bit ackIn, input bit ackIfAccept);
    logic [3:0] rowsAtEdge;
    mdl_t       nxt;
    bit         ackNow;
    #2;
    rowsAtEdge = rows_i;
    nxt        = modelNext(m, rowsAtEdge, 1'b0);
    ackNow     = ackIn || (ackIfAccept && nxt.accepted);
    keyAck_i   = ackNow;
    nxt        = modelNext(m, rowsAtEdge, ackNow);
    @(posedge clk_i);
    #1;
    keyAck_i = 1'b0;
    if (!rst_ni) m = resetModel();
    else m = nxt;
    checkOutput("cols", 32'(cols_o), 32'(colsOf(m.col)));
    checkOutput("code", 32'(keyCode_o), 32'(m.code));
    checkOutput("held", 32'(keyHeld_o), 32'(m.held));
    checkOutput("pend", 32'(keyPend_o), 32'(m.pend));
    if (keyPend_o === 1'b1 && !prevPend) pendRises++;
    prevPend = (keyPend_o === 1'b1);
  endtask

  task automatic runCycles(input int n, input bit ackIfAccept);
    repeat (n) stepCycle(1'b0, ackIfAccept);
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic assertReset(input int cycles);
    rst_ni = 1'b0;
    #1;
    checkOutput("rstCols", 32'(cols_o), 32'h E);
    checkOutput("rstCode", 32'(keyCode_o), 32'h0);
    checkOutput("rstHeld", 32'(keyHeld_o), 32'h0);
    checkOutput("rstPend", 32'(keyPend_o), 32'h0);
    m        = resetModel();
    prevPend = 1'b0;
    repeat (cycles) stepCycle(1'b0, 1'b0);
    rst_ni = 1'b1;
  endtask

  // Main sequence: directed scenarios followed by randomized presses.
  initial begin
    bit ok;
    int c, r, c2, r2, n;
    keyDown  = '0;
    keyAck_i = 1'b0;
    rst_ni   = 1'b1;
    m        = resetModel();
    #1;
    assertReset(2);

    $display("[TB] idle scan");
    runCycles(40, 1'b0);
    checkOutput("idlePend", 32'(keyPend_o), 32'h0);
    checkOutput("idleCode", 32'(keyCode_o), 32'h0);

    $display("[TB] hold key 5");
    pendRises = 0;
    applyStimulus(1, 1, 1'b1);
    runCycles(100, 1'b0);
    checkOutput("k5Code", 32'(keyCode_o), 32'(keyMap[1][1]));
    checkOutput("k5Held", 32'(keyHeld_o), 32'h1);
    checkOutput("k5Pend", 32'(keyPend_o), 32'h1);
    checkOutput("k5Cols", 32'(cols_o), 32'h D);
    applyStimulus(1, 1, 1'b0);
    runCycles(40, 1'b0);
    checkOutput("k5Rel", 32'(keyHeld_o), 32'h0);
    runCycles(20, 1'b0);

    $display("[TB] bouncing key D");
    stepCycle(1'b1, 1'b0);
    pendRises = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3, 3, (i % 2) == 0);
      runCycles(5, 1'b0);
    end
    applyStimulus(3, 3, 1'b1);
    runCycles(80, 1'b0);
    checkOutput("dRises", 32'(pendRises), 32'd1);
    checkOutput("dCode", 32'(keyCode_o), 32'(keyMap[3][3]));
    applyStimulus(3, 3, 1'b0);
    runCycles(50, 1'b0);

    $display("[TB] keys 4 and 7 together, ack on acceptance");
    stepCycle(1'b1, 1'b0);
    applyStimulus(0, 1, 1'b1);
    applyStimulus(0, 2, 1'b1);
    runCycles(100, 1'b1);
    checkOutput("k47Code", 32'(keyCode_o), 32'(keyMap[0][1]));
    checkOutput("k47Pend", 32'(keyPend_o), 32'h1);
    stepCycle(1'b1, 1'b0);
    checkOutput("k47Ack", 32'(keyPend_o), 32'h0);
    applyStimulus(0, 1, 1'b0);
    applyStimulus(0, 2, 1'b0);
    runCycles(50, 1'b0);

    $display("[TB] reset during debounce of E");
    applyStimulus(2, 3, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      stepCycle(1'b0, 1'b0);
      if (m.mode == M_DEB) ok = 1'b1;
    end
    checkOutput("reachDeb", 32'(ok), 32'h1);
    assertReset(3);
    runCycles(100, 1'b0);
    checkOutput("eCode", 32'(keyCode_o), 32'(keyMap[2][3]));
    checkOutput("ePend", 32'(keyPend_o), 32'h1);
    applyStimulus(2, 3, 1'b0);
    runCycles(50, 1'b0);

    $display("[TB] key A twice");
    stepCycle(1'b1, 1'b0);
    pendRises = 0;
    applyStimulus(3, 0, 1'b1);
    runCycles(100, 1'b0);
    checkOutput("a1Code", 32'(keyCode_o), 32'(keyMap[3][0]));
    stepCycle(1'b1, 1'b0);
    checkOutput("a1Ack", 32'(keyPend_o), 32'h0);
    applyStimulus(3, 0, 1'b0);
    runCycles(50, 1'b0);
    checkOutput("aRelCode", 32'(keyCode_o), 32'(keyMap[3][0]));
    applyStimulus(3, 0, 1'b1);
    runCycles(100, 1'b0);
    checkOutput("a2Pend", 32'(keyPend_o), 32'h1);
    checkOutput("a2Code", 32'(keyCode_o), 32'(keyMap[3][0]));
    checkOutput("aRises", 32'(pendRises), 32'd2);
    applyStimulus(3, 0, 1'b0);
    runCycles(50, 1'b0);

    $display("[TB] randomized presses");
    for (int it = 0; it < 14; it++) begin
      c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      n = $urandom_range(0, 4);
      for (int b = 0; b < n; b++) begin
        applyStimulus(c, r, (b % 2) == 0);
        runCycles($urandom_range(1, 6), 1'b0);
      end
      applyStimulus(c, r, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        c2 = $urandom_range(0, 3);
        r2 = $urandom_range(0, 3);
        applyStimulus(c2, r2, 1'b1);
      end
      runCycles($urandom_range(50, 110), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) stepCycle(1'b1, 1'b0);
      keyDown = '0;
      runCycles($urandom_range(45, 70), 1'b0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
